// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch between the PC and decode.
// Ports: clk/reset (async, active-high); redirect_valid/redirect_pc (branch/jump target);
//   imem_req/imem_addr/imem_ack/imem_data (single-outstanding memory handshake);
//   out_valid/out_ready/out_instr/out_pc (decode-facing valid/ready queue head).
// This file also holds the generic queue used to buffer fetched words.

// fifo: generic flushable queue, storage and pointers in flops.
// Latency: a word written on one edge is visible at rd_dat after that edge.
// Backpressure: rd_vld stays high until rd_rdy pops; writer must not push when full.
module fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       wr_vld,
  input  logic [WIDTH-1:0]           wr_dat,
  output logic                       rd_vld,
  input  logic                       rd_rdy,
  output logic [WIDTH-1:0]           rd_dat,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             pop;

  assign rd_vld = (count != '0);
  assign rd_dat = mem[rd_ptr];
  assign pop    = rd_vld && rd_rdy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      // Storage is cleared so the head reads as zero straight out of reset.
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      // Flush wins over any push/pop in the same cycle; a pop still counts
      // as taken by the consumer, its entry simply disappears with the rest.
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_vld) begin
        mem[wr_ptr] <= wr_dat;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({wr_vld, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// fetch_stage: owns the PC, fetches one word at a time, queues {pc, instr} for decode.
// Latency: request visible the cycle after the IDLE decision; entry visible the cycle after ack.
// Backpressure: no new fetch is started unless the queue has room after this cycle's pop.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
);

  localparam int          CW       = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [31:0] RESET_PC_A = {RESET_PC[31:2], 2'b00};

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // IDLE: no request outstanding. WAIT: live request. DROP: request squashed
  // by a redirect but still owed an ack by memory.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t       state_q;
  state_t       state_d;
  logic [31:0]  pc_q;
  logic [31:0]  pc_d;
  logic [31:0]  addr_q;
  logic [31:0]  addr_d;
  logic         push;
  logic         pop;
  logic [CW-1:0] count;
  logic [CW-1:0] count_after_pop;
  fetch_entry_t wr_entry;
  fetch_entry_t rd_entry;
  logic         unused_lsb;

  // The low two bits of a redirect target are discarded by design.
  assign unused_lsb = ^redirect_pc[1:0];

  assign pop             = out_valid && out_ready;
  assign count_after_pop = count - CW'(pop);

  assign wr_entry.pc    = pc_q;
  assign wr_entry.instr = imem_data;

  fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk    (clk),
    .rst    (reset),
    .flush  (redirect_valid),
    .wr_vld (push),
    .wr_dat (wr_entry),
    .rd_vld (out_valid),
    .rd_rdy (out_ready),
    .rd_dat (rd_entry),
    .count  (count)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    push    = 1'b0;

    case (state_q)
      IDLE: begin
        // Room is judged after this cycle's pop so a draining queue refills
        // without a bubble; a redirect suppresses the request this cycle.
        if (!redirect_valid && (count_after_pop < DEPTH_C)) begin
          state_d = WAIT;
          addr_d  = pc_q;
        end
      end
      WAIT: begin
        if (imem_ack) begin
          state_d = IDLE;
          if (!redirect_valid) begin
            push = 1'b1;
            pc_d = pc_q + 32'd4;
          end
        end else if (redirect_valid) begin
          // Memory still owes us this ack; keep the request up and discard it.
          state_d = DROP;
        end
      end
      DROP: begin
        if (imem_ack) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (redirect_valid) begin
      pc_d = {redirect_pc[31:2], 2'b00};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC_A;
      addr_q  <= RESET_PC_A;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
    end
  end

  // Both outputs come straight from flops, so the address cannot move while
  // a request (live or squashed) is outstanding.
  assign imem_req  = (state_q == WAIT) || (state_q == DROP);
  assign imem_addr = addr_q;
  assign out_instr = rd_entry.instr;
  assign out_pc    = rd_entry.pc;

endmodule
